// File: rtl/systolic_pkg.sv
// Shared FSM encoding, default widths and a timing helper for the systolic
// matrix-multiply tile and its processing elements.
package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ACC_W      = 24;
    localparam int DEF_K_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DRAIN = 2'b11
    } tile_state_t;

    // Cycles after the last accepted beat until it has passed the far-corner PE
    function automatic int flush_cycles(input int n);
        return (2 * n) - 1;
    endfunction

endpackage

// File: rtl/systolic_matmul_tile_mac_pe.sv
// Output-stationary processing element: forwards operands and their valid
// tags one hop right/down and accumulates a signed product when both are tagged.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_tag_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_tag_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_tag_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_tag_out,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] a_ext_s;
    logic signed [2*DATA_W-1:0] b_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    acc_r;
    logic [DATA_W-1:0]          a_fwd_r;
    logic [DATA_W-1:0]          b_fwd_r;
    logic                       a_tag_r;
    logic                       b_tag_r;

    // Full-precision signed product, sign-extended to the accumulator width
    always_comb begin
        a_ext_s    = (2*DATA_W)'($signed(a_in));
        b_ext_s    = (2*DATA_W)'($signed(b_in));
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = ACC_W'(prod_s);
    end

    // One-hop operand and tag forwarding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_fwd_r <= {DATA_W{1'b0}};
            b_fwd_r <= {DATA_W{1'b0}};
            a_tag_r <= 1'b0;
            b_tag_r <= 1'b0;
        end else begin
            a_fwd_r <= a_in;
            b_fwd_r <= b_in;
            a_tag_r <= a_tag_in;
            b_tag_r <= b_tag_in;
        end
    end

    // Accumulator: wraps modulo 2^ACC_W, only tagged operand pairs contribute
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (a_tag_in && b_tag_in) begin
            acc_r <= acc_r + prod_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign a_out     = a_fwd_r;
    assign b_out     = b_fwd_r;
    assign a_tag_out = a_tag_r;
    assign b_tag_out = b_tag_r;
    assign acc       = acc_r;

endmodule

// File: rtl/systolic_matmul_tile.sv
// N x N output-stationary systolic tile: accepts k_len operand vector pairs,
// skews them into a mac_pe grid, then streams the result matrix out row by row.
module systolic_matmul_tile
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int K_W        = DEF_K_W,
    localparam int IDX_W     = $clog2(ARRAY_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [K_W-1:0]             k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0] a_in,
    input  logic [ARRAY_SIZE*DATA_W-1:0] b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ARRAY_SIZE*ACC_W-1:0] out_row,
    output logic [IDX_W-1:0]           out_row_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int FLUSH_N    = flush_cycles(ARRAY_SIZE);
    localparam int FLUSH_W    = $clog2(FLUSH_N);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_N - 1);
    localparam logic [IDX_W-1:0]   LAST_ROW   = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [K_W-1:0]     K_ONE      = K_W'(1'b1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1'b1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1'b1);

    tile_state_t state_r;
    tile_state_t next_state_s;

    logic [K_W-1:0]     k_len_r;
    logic [K_W-1:0]     beat_cnt_r;
    logic [FLUSH_W-1:0] flush_cnt_r;

    logic                          in_ready_r;
    logic                          out_valid_r;
    logic                          busy_r;
    logic                          done_r;
    logic [ARRAY_SIZE*ACC_W-1:0]   out_row_r;
    logic [IDX_W-1:0]              out_row_idx_r;

    logic                          start_ok_s;
    logic                          accept_s;
    logic                          last_beat_s;
    logic                          drain_hs_s;
    logic                          last_row_s;
    logic [IDX_W-1:0]              row_sel_s;
    logic [ARRAY_SIZE*ACC_W-1:0]   row_mux_s;

    logic [DATA_W-1:0] a_h     [ARRAY_SIZE][ARRAY_SIZE+1];
    logic              a_tag_h [ARRAY_SIZE][ARRAY_SIZE+1];
    logic [DATA_W-1:0] b_v     [ARRAY_SIZE+1][ARRAY_SIZE];
    logic              b_tag_v [ARRAY_SIZE+1][ARRAY_SIZE];
    logic [ACC_W-1:0]  acc_s   [ARRAY_SIZE][ARRAY_SIZE];

    assign start_ok_s  = (state_r == ST_IDLE) && start && (k_len != {K_W{1'b0}});
    assign accept_s    = in_valid && in_ready_r;
    assign last_beat_s = accept_s && (beat_cnt_r == (k_len_r - K_ONE));
    assign drain_hs_s  = (state_r == ST_DRAIN) && out_valid_r && out_ready;
    assign last_row_s  = drain_hs_s && (out_row_idx_r == LAST_ROW);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) next_state_s = ST_LOAD;
                else            next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (last_beat_s) next_state_s = ST_FLUSH;
                else             next_state_s = ST_LOAD;
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) next_state_s = ST_DRAIN;
                else                           next_state_s = ST_FLUSH;
            end
            ST_DRAIN: begin
                if (last_row_s) next_state_s = ST_IDLE;
                else            next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: which result row is presented next and its contents.
    // Row 0 is captured on FLUSH exit; its PEs finished long before the far corner.
    always_comb begin
        row_sel_s = out_row_idx_r;
        if (state_r == ST_FLUSH) begin
            row_sel_s = {IDX_W{1'b0}};
        end else if (drain_hs_s && !last_row_s) begin
            row_sel_s = out_row_idx_r + IDX_ONE;
        end else begin
            row_sel_s = out_row_idx_r;
        end
        row_mux_s = {(ARRAY_SIZE*ACC_W){1'b0}};
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            row_mux_s[j*ACC_W +: ACC_W] = acc_s[row_sel_s][j];
        end
    end

    // Tile length latch, beat counter and flush timer
    always_ff @(posedge clk) begin
        if (reset) begin
            k_len_r     <= {K_W{1'b0}};
            beat_cnt_r  <= {K_W{1'b0}};
            flush_cnt_r <= {FLUSH_W{1'b0}};
        end else begin
            if (start_ok_s) begin
                k_len_r    <= k_len;
                beat_cnt_r <= {K_W{1'b0}};
            end else if (accept_s) begin
                k_len_r    <= k_len_r;
                beat_cnt_r <= beat_cnt_r + K_ONE;
            end else begin
                k_len_r    <= k_len_r;
                beat_cnt_r <= beat_cnt_r;
            end
            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FLUSH_ONE;
            end else begin
                flush_cnt_r <= {FLUSH_W{1'b0}};
            end
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            out_row_r     <= {(ARRAY_SIZE*ACC_W){1'b0}};
            out_row_idx_r <= {IDX_W{1'b0}};
        end else begin
            in_ready_r  <= (next_state_s == ST_LOAD);
            out_valid_r <= (next_state_s == ST_DRAIN);
            busy_r      <= (next_state_s != ST_IDLE);
            done_r      <= last_row_s;
            if (next_state_s == ST_DRAIN) begin
                out_row_r     <= row_mux_s;
                out_row_idx_r <= row_sel_s;
            end else begin
                out_row_r     <= {(ARRAY_SIZE*ACC_W){1'b0}};
                out_row_idx_r <= {IDX_W{1'b0}};
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign out_row     = out_row_r;
    assign out_row_idx = out_row_idx_r;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_skew
        logic [DATA_W-1:0] a_dly_r [0:i];
        logic              a_tag_r [0:i];
        logic [DATA_W-1:0] b_dly_r [0:i];
        logic              b_tag_r [0:i];

        // Lane i of each operand is delayed i extra cycles behind the capture stage
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d <= i; d++) begin
                    a_dly_r[d] <= {DATA_W{1'b0}};
                    a_tag_r[d] <= 1'b0;
                    b_dly_r[d] <= {DATA_W{1'b0}};
                    b_tag_r[d] <= 1'b0;
                end
            end else begin
                a_dly_r[0] <= a_in[i*DATA_W +: DATA_W];
                a_tag_r[0] <= accept_s;
                b_dly_r[0] <= b_in[i*DATA_W +: DATA_W];
                b_tag_r[0] <= accept_s;
                for (int d = 1; d <= i; d++) begin
                    a_dly_r[d] <= a_dly_r[d-1];
                    a_tag_r[d] <= a_tag_r[d-1];
                    b_dly_r[d] <= b_dly_r[d-1];
                    b_tag_r[d] <= b_tag_r[d-1];
                end
            end
        end

        assign a_h[i][0]     = a_dly_r[i];
        assign a_tag_h[i][0] = a_tag_r[i];
        assign b_v[0][i]     = b_dly_r[i];
        assign b_tag_v[0][i] = b_tag_r[i];
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
        for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
            mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .reset     (reset),
                .clear     (start_ok_s),
                .a_in      (a_h[i][j]),
                .a_tag_in  (a_tag_h[i][j]),
                .b_in      (b_v[i][j]),
                .b_tag_in  (b_tag_v[i][j]),
                .a_out     (a_h[i][j+1]),
                .a_tag_out (a_tag_h[i][j+1]),
                .b_out     (b_v[i+1][j]),
                .b_tag_out (b_tag_v[i+1][j]),
                .acc       (acc_s[i][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_matmul_tile.sv
// Self-checking bench: a 24-bit and a 16-bit accumulator tile run in lockstep,
// expected rows are queued as tiles are issued and compared as rows drain.
module tb_systolic_matmul_tile;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int AW16 = 16;
    localparam int KW   = 8;

    logic clk = 1'b0;
    logic reset, start, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [N*DW-1:0] a_in, b_in;

    logic in_ready, out_valid, busy, done;
    logic [N*AW-1:0] out_row;
    logic [1:0]      out_row_idx;
    logic in_ready16, out_valid16, busy16, done16;
    logic [N*AW16-1:0] out_row16;
    logic [1:0]        out_row_idx16;

    typedef struct packed {
        logic [1:0]        idx;
        logic [N*AW-1:0]   r24;
        logic [N*AW16-1:0] r16;
    } exp_t;

    typedef struct {
        int     k;
        int     a_val;
        int     b_val;
        int     gap;
        int     stall;
        int     busy_start;
        longint e24;
        longint e16;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [6];
    int   a_mat [16][N];
    int   b_mat [16][N];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    systolic_matmul_tile #(.ARRAY_SIZE(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy), .done(done)
    );

    systolic_matmul_tile #(.ARRAY_SIZE(N), .DATA_W(DW), .ACC_W(AW16), .K_W(KW)) dut16 (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_row_idx(out_row_idx16), .busy(busy16), .done(done16)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        check(nm, {in_ready, out_valid, busy, done, out_row_idx, out_row}, 128'd0);
        check({nm, "_16"}, {in_ready16, out_valid16, busy16, done16, out_row_idx16, out_row16}, 128'd0);
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                a_mat[kk][i] = int'($urandom_range(255, 0)) - 128;
                b_mat[kk][i] = int'($urandom_range(255, 0)) - 128;
            end
        end
    endtask

    task automatic push_model(input int k);
        exp_t   e;
        longint sum;
        for (int r = 0; r < N; r++) begin
            e.idx = 2'(r);
            for (int j = 0; j < N; j++) begin
                sum = 64'sd0;
                for (int kk = 0; kk < k; kk++) begin
                    sum += longint'(a_mat[kk][r]) * longint'(b_mat[kk][j]);
                end
                e.r24[j*AW +: AW]     = sum[AW-1:0];
                e.r16[j*AW16 +: AW16] = sum[AW16-1:0];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic push_const(input longint e24, input longint e16);
        exp_t e;
        for (int r = 0; r < N; r++) begin
            e.idx = 2'(r);
            for (int j = 0; j < N; j++) begin
                e.r24[j*AW +: AW]     = e24[AW-1:0];
                e.r16[j*AW16 +: AW16] = e16[AW16-1:0];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic set_lanes(input int beat);
        for (int i = 0; i < N; i++) begin
            a_in[i*DW +: DW] = DW'(a_mat[beat][i]);
            b_in[i*DW +: DW] = DW'(b_mat[beat][i]);
        end
    endtask

    task automatic run_tile(input int k, input int gap, input int stall, input int busy_start);
        int   cyc;
        int   beat;
        int   slot;
        logic rdy;
        logic stable;
        logic [N*AW-1:0] held;
        exp_t e;
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        beat = 0;
        slot = 0;
        cyc  = 0;
        while (beat < k && cyc < 200) begin
            rdy      = in_ready;
            in_valid = (gap == 0) ? 1'b1 : ((slot % 3) == 0);
            if (in_valid) begin
                set_lanes(beat);
            end else begin
                a_in = $urandom;
                b_in = $urandom;
            end
            tick();
            if (in_valid && rdy) beat++;
            slot++;
            cyc++;
        end
        in_valid = 1'b0;
        check("beats_accepted", beat, k);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("first_out_latency", cyc, 2 * N - 1);
        for (int r = 0; r < N; r++) begin
            cyc = 0;
            while (!out_valid && cyc < 50) begin
                tick();
                cyc++;
            end
            check("row_valid", {out_valid, out_valid16}, 2'b11);
            held   = out_row;
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                start     = (busy_start != 0);
                k_len     = KW'(2);
                tick();
                if (out_row !== held || !out_valid || !busy) stable = 1'b0;
            end
            start = 1'b0;
            if (stall > 0) check("row_stable", stable, 1'b1);
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("row_idx", {out_row_idx, out_row_idx16}, {e.idx, e.idx});
                check("row_acc24", out_row, e.r24);
                check("row_acc16", out_row16, e.r16);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("done_pulse", {done, out_valid, busy, done16, out_valid16, busy16}, 6'b100100);
        tick();
        check("done_single", {done, busy, done16, busy16}, 4'b0000);
    endtask

    initial begin
        logic quiet;
        int   k;
        vecs[0] = '{3, -128, -128, 0, 0, 0,  49152, -16384};
        vecs[1] = '{3,  127, -128, 0, 0, 0, -48768,  16768};
        vecs[2] = '{4,  127,  127, 0, 0, 0,  64516,  -1020};
        vecs[3] = '{5,    3,   -7, 0, 0, 0,   -105,   -105};
        vecs[4] = '{5,    3,   -7, 1, 0, 0,   -105,   -105};
        vecs[5] = '{1,   -1,    1, 0, 3, 1,     -1,     -1};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        k_len = 8'd0; a_in = 32'd0; b_in = 32'd0;
        repeat (3) tick();
        check_zero("reset_state");
        reset = 1'b0;
        tick();
        check_zero("after_release");

        // Identity A against B = 1..16: result rows equal B
        for (int kk = 0; kk < N; kk++) begin
            for (int i = 0; i < N; i++) begin
                a_mat[kk][i] = (i == kk) ? 1 : 0;
                b_mat[kk][i] = 4 * kk + i + 1;
            end
        end
        push_model(N);
        run_tile(N, 0, 0, 0);

        for (int v = 0; v < 6; v++) begin
            for (int kk = 0; kk < vecs[v].k; kk++) begin
                for (int i = 0; i < N; i++) begin
                    a_mat[kk][i] = vecs[v].a_val;
                    b_mat[kk][i] = vecs[v].b_val;
                end
            end
            push_const(vecs[v].e24, vecs[v].e16);
            run_tile(vecs[v].k, vecs[v].gap, vecs[v].stall, vecs[v].busy_start);
        end

        // Same random operands with and without input bubbles
        fill_random(5);
        push_model(5);
        run_tile(5, 0, 0, 0);
        push_model(5);
        run_tile(5, 1, 0, 0);

        // Output back-pressure with start pulses while busy
        fill_random(4);
        push_model(4);
        run_tile(4, 0, 3, 1);

        // start with k_len = 0 is ignored
        start = 1'b1;
        k_len = 8'd0;
        tick();
        start = 1'b0;
        check("zero_k_busy", {busy, in_ready, busy16}, 3'b000);
        tick();
        check("zero_k_idle", {busy, in_ready, busy16}, 3'b000);

        // Reset in the middle of LOAD after two beats
        fill_random(4);
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        set_lanes(0);
        tick();
        set_lanes(1);
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check_zero("mid_reset_1");
        tick();
        check_zero("mid_reset_2");
        reset = 1'b0;
        tick();
        check_zero("mid_reset_release");
        quiet = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid || busy || out_valid16 || done) quiet = 1'b0;
        end
        check("mid_reset_no_output", quiet, 1'b1);
        fill_random(4);
        push_model(4);
        run_tile(4, 0, 0, 0);

        for (int t = 0; t < 3; t++) begin
            k = int'($urandom_range(8, 1));
            fill_random(k);
            push_model(k);
            run_tile(k, int'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 0);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
